regfile_mp: RTL and testbench

- Parametrised multi-port successor to the CPU register file: generic data width and depth, NRD registered read ports, two write ports with a fixed collision priority, and write-to-read bypass.
- Adds a multi-cycle sweep-clear engine, so software or the pipeline can zero the file without asserting global reset.
- Sits between the decode stage (read) and the writeback stage (two retire slots) of the MIPS datapath.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_mp_if.sv | 40 ++++
 rtl/regfile_rdport.sv | 59 +++++
 rtl/regfile_mp.sv | 113 +++++++++++
 tb/tb_regfile_mp.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
// Holds the default data/address widths used by the decode and writeback
// stages, the sweep-clear FSM state encoding and the depth helper.
package regfile_pkg;

    localparam int unsigned DefDw = 32;
    localparam int unsigned DefAw = 5;

    typedef enum logic {
        StIdle  = 1'b0,
        StClear = 1'b1
    } clr_state_e;

    function automatic int unsigned depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp.
// master: decode/writeback side (drives enables, addresses, data, clr_req;
//         receives rd and busy).
// slave:  the register file.
//   ena      global enable
//   we0/wa0/wd0, we1/wa1/wd1  two write ports, port 1 is the younger slot
//   ra       NRD packed read addresses, port i at [i*AW +: AW]
//   rd       NRD packed registered read data, port i at [i*DW +: DW]
//   clr_req  single-cycle sweep-clear request
//   busy     sweep clear in progress
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int unsigned DW  = DefDw,
    parameter int unsigned AW  = DefAw,
    parameter int unsigned NRD = 2
);
    logic              ena;
    logic              we0;
    logic [AW-1:0]     wa0;
    logic [DW-1:0]     wd0;
    logic              we1;
    logic [AW-1:0]     wa1;
    logic [DW-1:0]     wd1;
    logic [NRD*AW-1:0] ra;
    logic [NRD*DW-1:0] rd;
    logic              clr_req;
    logic              busy;

    modport master (
        output ena, we0, wa0, wd0, we1, wa1, wd1, ra, clr_req,
        input  rd, busy
    );

    modport slave (
        input  ena, we0, wa0, wd0, we1, wa1, wd1, ra, clr_req,
        output rd, busy
    );

endinterface

// File: rtl/regfile_rdport.sv
// One registered read port of the register file.
//   clk_i, rst_ni       clock, async active-low reset
//   ena_i               global enable; rd_o holds when low
//   ra_i                read address
//   mem_i               current array contents
//   wr0_en_i/wa0_i/wd0_i, wr1_en_i/wa1_i/wd1_i
//                       write ports as they will commit this edge (enables
//                       already qualified: nonzero address, idle, enabled)
//   rd_o                registered read data
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int unsigned DW    = DefDw,
    parameter int unsigned AW    = DefAw,
    parameter int unsigned Depth = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          ena_i,
    input  logic [AW-1:0] ra_i,
    input  logic [DW-1:0] mem_i [Depth],
    input  logic          wr0_en_i,
    input  logic [AW-1:0] wa0_i,
    input  logic [DW-1:0] wd0_i,
    input  logic          wr1_en_i,
    input  logic [AW-1:0] wa1_i,
    input  logic [DW-1:0] wd1_i,
    output logic [DW-1:0] rd_o
);

    logic [DW-1:0] rd_d, rd_q;

    // Bypass checks port 1 first so it matches the array's collision priority.
    always_comb begin
        rd_d = rd_q;
        if (ena_i) begin
            if (ra_i == '0) begin
                rd_d = '0;
            end else if (wr1_en_i && (wa1_i == ra_i)) begin
                rd_d = wd1_i;
            end else if (wr0_en_i && (wa0_i == ra_i)) begin
                rd_d = wd0_i;
            end else begin
                rd_d = mem_i[ra_i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign rd_o = rd_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass and sweep clear.
//   clk   clock, rising edge
//   rst   async active-low reset, clears array, read registers and FSM
//   bus   regfile_mp_if slave: two write ports, NRD registered read ports,
//         clr_req/busy sweep-clear handshake, global ena
// Entry 0 is hardwired to zero. During a sweep, writes are dropped and the
// bypass is disabled; reads see swept entries as zero.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DW  = DefDw,
    parameter int unsigned AW  = DefAw,
    parameter int unsigned NRD = 2
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);

    localparam int unsigned Depth = depth(AW);

    logic [DW-1:0]     mem_q [Depth];
    clr_state_e        state_q;
    logic              busy_q;
    logic [AW-1:0]     idx_q;
    logic              wr_ok, wr0_en, wr1_en, sweep_en;
    logic [DW-1:0]     rd_w [NRD];
    logic [NRD*DW-1:0] rd_flat;

    // Writes are also dropped on the cycle a clear request is accepted.
    assign wr_ok    = bus.ena && (state_q == StIdle) && !bus.clr_req;
    assign wr0_en   = wr_ok && bus.we0 && (bus.wa0 != '0);
    assign wr1_en   = wr_ok && bus.we1 && (bus.wa1 != '0);
    assign sweep_en = bus.ena && (state_q == StClear);

    // Port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (sweep_en) begin
            mem_q[idx_q] <= '0;
        end else begin
            if (wr0_en) begin
                mem_q[bus.wa0] <= bus.wd0;
            end
            if (wr1_en) begin
                mem_q[bus.wa1] <= bus.wd1;
            end
        end
    end

    // Sweep-clear FSM; busy is registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            idx_q   <= AW'(1);
        end else if (bus.ena) begin
            unique case (state_q)
                StIdle: begin
                    if (bus.clr_req) begin
                        state_q <= StClear;
                        busy_q  <= 1'b1;
                        idx_q   <= AW'(1);
                    end
                end
                StClear: begin
                    if (&idx_q) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        idx_q   <= AW'(1);
                    end else begin
                        idx_q <= idx_q + AW'(1);
                    end
                end
            endcase
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        regfile_rdport #(
            .DW    (DW),
            .AW    (AW),
            .Depth (Depth)
        ) u_rdport (
            .clk_i    (clk),
            .rst_ni   (rst),
            .ena_i    (bus.ena),
            .ra_i     (bus.ra[g*AW +: AW]),
            .mem_i    (mem_q),
            .wr0_en_i (wr0_en),
            .wa0_i    (bus.wa0),
            .wd0_i    (bus.wd0),
            .wr1_en_i (wr1_en),
            .wa1_i    (bus.wa1),
            .wd1_i    (bus.wd1),
            .rd_o     (rd_w[g])
        );
    end

    always_comb begin
        rd_flat = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_flat[i*DW +: DW] = rd_w[i];
        end
    end

    assign bus.rd   = rd_flat;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (DW=32, AW=5, NRD=2).
module tb_regfile_mp;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    regfile_mp_if #(.DW(32), .AW(5), .NRD(2)) bus ();

    regfile_mp #(.DW(32), .AW(5), .NRD(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
        bus.ra = {a1, a0};
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.busy !== 1'b1) break;
            n++;
            step();
        end
    endtask

    initial begin
        int nb;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        bus.ena = 1'b1;
        bus.we0 = 1'b0; bus.wa0 = '0; bus.wd0 = '0;
        bus.we1 = 1'b0; bus.wa1 = '0; bus.wd1 = '0;
        bus.ra = '0;
        bus.clr_req = 1'b0;
        step();
        step();
        check("reset_rd", bus.rd[31:0], 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        rst = 1'b1;
        step();

        // Basic write then read
        bus.we0 = 1'b1; bus.wa0 = 5'd5; bus.wd0 = 32'hDEADBEEF;
        step();
        bus.we0 = 1'b0;
        set_ra(5'd5, 5'd0);
        step();
        check("basic_rd0", bus.rd[31:0], 32'hDEADBEEF);
        check("basic_rd1_r0", bus.rd[63:32], 32'h0);

        // Collision: port 1 wins, bypass follows the same priority
        bus.we0 = 1'b1; bus.wa0 = 5'd7; bus.wd0 = 32'h11;
        bus.we1 = 1'b1; bus.wa1 = 5'd7; bus.wd1 = 32'h22;
        set_ra(5'd7, 5'd5);
        step();
        check("collide_bypass", bus.rd[31:0], 32'h22);
        check("other_port_rd1", bus.rd[63:32], 32'hDEADBEEF);
        bus.we0 = 1'b0; bus.we1 = 1'b0;
        step();
        check("collide_stored", bus.rd[31:0], 32'h22);

        // Single-port bypass on port 0
        bus.we0 = 1'b1; bus.wa0 = 5'd6; bus.wd0 = 32'h1234_5678;
        set_ra(5'd7, 5'd6);
        step();
        bus.we0 = 1'b0;
        check("bypass_p0", bus.rd[63:32], 32'h1234_5678);

        // r0 protection, including the bypass cycle
        bus.we0 = 1'b1; bus.wa0 = 5'd0; bus.wd0 = 32'hFFFFFFFF;
        bus.we1 = 1'b1; bus.wa1 = 5'd0; bus.wd1 = 32'hFFFFFFFF;
        set_ra(5'd0, 5'd0);
        step();
        check("r0_bypass_rd0", bus.rd[31:0], 32'h0);
        check("r0_bypass_rd1", bus.rd[63:32], 32'h0);
        bus.we0 = 1'b0; bus.we1 = 1'b0;
        step();
        check("r0_stored", bus.rd[31:0], 32'h0);

        // ena freeze
        bus.we0 = 1'b1; bus.wa0 = 5'd3; bus.wd0 = 32'h5;
        step();
        bus.we0 = 1'b0;
        set_ra(5'd3, 5'd0);
        step();
        check("freeze_pre", bus.rd[31:0], 32'h5);
        bus.ena = 1'b0;
        bus.we0 = 1'b1; bus.wa0 = 5'd3; bus.wd0 = 32'h9;
        bus.clr_req = 1'b1;
        set_ra(5'd5, 5'd0);
        step();
        check("freeze_rd_hold", bus.rd[31:0], 32'h5);
        check("freeze_busy", 32'(bus.busy), 32'h0);
        bus.ena = 1'b1; bus.we0 = 1'b0; bus.clr_req = 1'b0;
        set_ra(5'd3, 5'd0);
        step();
        check("freeze_r3", bus.rd[31:0], 32'h5);
        check("freeze_busy_after", 32'(bus.busy), 32'h0);

        // Sweep clear
        for (int i = 1; i < 32; i++) begin
            bus.we0 = 1'b1; bus.wa0 = 5'(i); bus.wd0 = 32'(i);
            step();
        end
        bus.clr_req = 1'b1;
        bus.we0 = 1'b1; bus.wa0 = 5'd4; bus.wd0 = 32'h77;
        set_ra(5'd4, 5'd0);
        step();
        bus.clr_req = 1'b0; bus.we0 = 1'b0;
        check("accept_wr_dropped", bus.rd[31:0], 32'h4);
        nb = (bus.busy === 1'b1) ? 1 : 0;
        for (int c = 1; c <= 31; c++) begin
            if (c == 10) set_ra(5'd2, 5'd20);
            if (c == 12) begin bus.we0 = 1'b1; bus.wa0 = 5'd9; bus.wd0 = 32'hABCD; end
            if (c == 13) begin bus.we0 = 1'b0; set_ra(5'd9, 5'd20); end
            bus.clr_req = (c == 20);
            step();
            if (c == 1) check("sweep_c1_r4", bus.rd[31:0], 32'h4);
            if (c == 10) begin
                check("sweep_c10_r2", bus.rd[31:0], 32'h0);
                check("sweep_c10_r20", bus.rd[63:32], 32'd20);
            end
            if (c == 13) check("sweep_wr_dropped", bus.rd[31:0], 32'h0);
            if (bus.busy === 1'b1) nb++;
        end
        bus.clr_req = 1'b0;
        check("sweep_busy_cycles", 32'(nb), 32'd31);
        check("sweep_busy_end", 32'(bus.busy), 32'h0);
        for (int i = 0; i < 32; i++) begin
            set_ra(5'(i), 5'(31 - i));
            step();
            check($sformatf("post_sweep_r%0d", i), bus.rd[31:0], 32'h0);
        end

        // Reset mid-sweep
        bus.we0 = 1'b1; bus.wa0 = 5'd15; bus.wd0 = 32'hF;
        bus.we1 = 1'b1; bus.wa1 = 5'd31; bus.wd1 = 32'h1F;
        step();
        bus.we0 = 1'b0; bus.we1 = 1'b0;
        set_ra(5'd15, 5'd31);
        step();
        check("preload_r15", bus.rd[31:0], 32'hF);
        check("preload_r31", bus.rd[63:32], 32'h1F);
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        for (int c = 1; c <= 4; c++) step();
        check("midsweep_busy", 32'(bus.busy), 32'h1);
        rst = 1'b0;
        #1;
        check("rst_busy_now", 32'(bus.busy), 32'h0);
        check("rst_rd_now", bus.rd[31:0], 32'h0);
        step();
        rst = 1'b1;
        step();
        step();
        check("rst_r15", bus.rd[31:0], 32'h0);
        check("rst_r31", bus.rd[63:32], 32'h0);
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        count_busy(nb);
        check("resweep_busy_cycles", 32'(nb), 32'd31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
